// File: rtl/i2c_pkg.sv
// i2c_pkg
//   Definitions shared by the I2C target and master blocks: the protocol
//   state enum, the bus levels that mean ACK/NACK, the number of data bits
//   in a byte, and small helpers for the bit counter and open-drain drive.
package i2c_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_WR_DATA,
    ST_WR_ACK,
    ST_RD_DATA,
    ST_RD_ACK
  } i2c_state_t;

  localparam logic       ACK_LEVEL     = 1'b0;
  localparam logic       NACK_LEVEL    = 1'b1;
  localparam logic [3:0] BITS_PER_BYTE = 4'd8;

  // The bit counter stops at a full byte so stray SCL pulses cannot wrap it.
  function automatic logic [3:0] bit_cnt_inc(input logic [3:0] cnt);
    return (cnt >= BITS_PER_BYTE) ? BITS_PER_BYTE : cnt + 4'd1;
  endfunction

  // Open-drain output: the only way to put a 0 on the bus is to pull it low.
  function automatic logic drive_for_level(input logic level);
    return ~level;
  endfunction

endpackage

// File: rtl/i2c_line_sync.sv
// i2c_line_sync
//   Brings the asynchronous SCL/SDA bus lines into the clock domain and
//   derives the bus events the protocol FSM works from.
//
// Ports
//   clock      system clock
//   reset      asynchronous active-low reset
//   scl_in     raw bus SCL level
//   sda_in     raw bus SDA level
//   sda        synchronized SDA level
//   scl_rise   one-cycle pulse on synchronized SCL rising edge
//   scl_fall   one-cycle pulse on synchronized SCL falling edge
//   start_det  one-cycle pulse: SDA fell while SCL high
//   stop_det   one-cycle pulse: SDA rose while SCL high
module i2c_line_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clock,
  input  logic reset,
  input  logic scl_in,
  input  logic sda_in,
  output logic sda,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det
);

  logic [SYNC_STAGES-1:0] scl_pipe;
  logic [SYNC_STAGES-1:0] sda_pipe;
  logic                   scl_s;
  logic                   sda_s;
  logic                   scl_d;
  logic                   sda_d;

  // Synchronizer chains plus one extra delayed copy for edge detection.
  // Everything presets to 1 so that leaving reset looks like an idle bus
  // and never fabricates a START.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      scl_pipe <= '1;
      sda_pipe <= '1;
      scl_d    <= 1'b1;
      sda_d    <= 1'b1;
    end else begin
      scl_pipe <= {scl_pipe[SYNC_STAGES-2:0], scl_in};
      sda_pipe <= {sda_pipe[SYNC_STAGES-2:0], sda_in};
      scl_d    <= scl_s;
      sda_d    <= sda_s;
    end
  end

  assign scl_s = scl_pipe[SYNC_STAGES-1];
  assign sda_s = sda_pipe[SYNC_STAGES-1];

  assign sda       = sda_s;
  assign scl_rise  =  scl_s & ~scl_d;
  assign scl_fall  = ~scl_s &  scl_d;
  assign start_det =  scl_s &  sda_d & ~sda_s;
  assign stop_det  =  scl_s & ~sda_d &  sda_s;

endmodule

// File: rtl/i2c_target.sv
// i2c_target
//   7-bit-address I2C target. Receives written bytes into rx_data and
//   returns tx_data on reads, driving SDA through an open-drain enable.
//
// Ports
//   clock     system clock (at least 8x SCL rate)
//   reset     asynchronous active-low reset
//   scl_in    bus SCL level (asynchronous)
//   sda_in    bus SDA level (asynchronous)
//   sda_oe    1 = pull SDA low, 0 = release
//   tx_data   byte returned on a read, captured at the start of each byte
//   rx_data   last byte written by the master
//   rx_valid  one-cycle pulse when rx_data updates
//   tx_load   one-cycle pulse when tx_data is captured
//   busy      high from own-address match until STOP, repeated START or NACK
module i2c_target
  import i2c_pkg::*;
#(
  parameter logic [6:0] ADDRESS     = 7'h50,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       sda_oe,
  input  logic [7:0] tx_data,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       tx_load,
  output logic       busy
);

  logic sda;
  logic scl_rise;
  logic scl_fall;
  logic start_det;
  logic stop_det;

  i2c_state_t state, state_nxt;
  logic [3:0] bit_cnt, bit_cnt_nxt;
  logic [7:0] shift, shift_nxt;
  logic [7:0] rx_data_nxt;
  logic       sda_oe_nxt;
  logic       rx_valid_nxt;
  logic       tx_load_nxt;
  logic       busy_nxt;

  i2c_line_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_line_sync (
    .clock    (clock),
    .reset    (reset),
    .scl_in   (scl_in),
    .sda_in   (sda_in),
    .sda      (sda),
    .scl_rise (scl_rise),
    .scl_fall (scl_fall),
    .start_det(start_det),
    .stop_det (stop_det)
  );

  // State and datapath registers. Reset is asynchronous so that SDA is
  // released immediately even if the clock is stalled mid-transfer.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state    <= ST_IDLE;
      bit_cnt  <= '0;
      shift    <= '0;
      sda_oe   <= 1'b0;
      rx_data  <= '0;
      rx_valid <= 1'b0;
      tx_load  <= 1'b0;
      busy     <= 1'b0;
    end else begin
      state    <= state_nxt;
      bit_cnt  <= bit_cnt_nxt;
      shift    <= shift_nxt;
      sda_oe   <= sda_oe_nxt;
      rx_data  <= rx_data_nxt;
      rx_valid <= rx_valid_nxt;
      tx_load  <= tx_load_nxt;
      busy     <= busy_nxt;
    end
  end

  // Protocol sequencing. START/STOP are checked ahead of any SCL edge so a
  // bus condition always wins and drops whatever byte was in flight. Data
  // bits are shifted in on SCL rising edges; the SDA drive only moves on
  // SCL falling edges, when the bus allows SDA to change. In the ACK states
  // the counter just records that the 9th rising edge has happened, so the
  // exit waits for the falling edge that ends that clock.
  always_comb begin
    state_nxt    = state;
    bit_cnt_nxt  = bit_cnt;
    shift_nxt    = shift;
    sda_oe_nxt   = sda_oe;
    rx_data_nxt  = rx_data;
    rx_valid_nxt = 1'b0;
    tx_load_nxt  = 1'b0;
    busy_nxt     = busy;

    if (start_det) begin
      state_nxt   = ST_ADDR;
      bit_cnt_nxt = '0;
      sda_oe_nxt  = 1'b0;
      busy_nxt    = 1'b0;
    end else if (stop_det) begin
      state_nxt   = ST_IDLE;
      bit_cnt_nxt = '0;
      sda_oe_nxt  = 1'b0;
      busy_nxt    = 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
        end

        ST_ADDR: begin
          if (scl_rise) begin
            shift_nxt   = {shift[6:0], sda};
            bit_cnt_nxt = bit_cnt_inc(bit_cnt);
          end else if (scl_fall && bit_cnt == BITS_PER_BYTE) begin
            bit_cnt_nxt = '0;
            if (shift[7:1] == ADDRESS) begin
              state_nxt  = ST_ADDR_ACK;
              sda_oe_nxt = drive_for_level(ACK_LEVEL);
              busy_nxt   = 1'b1;
            end else begin
              state_nxt  = ST_IDLE;
            end
          end
        end

        ST_ADDR_ACK: begin
          if (scl_rise) begin
            bit_cnt_nxt = bit_cnt_inc(bit_cnt);
          end else if (scl_fall && bit_cnt != 4'd0) begin
            bit_cnt_nxt = '0;
            if (shift[0]) begin
              state_nxt   = ST_RD_DATA;
              shift_nxt   = tx_data;
              tx_load_nxt = 1'b1;
              sda_oe_nxt  = drive_for_level(tx_data[7]);
            end else begin
              state_nxt  = ST_WR_DATA;
              sda_oe_nxt = 1'b0;
            end
          end
        end

        ST_WR_DATA: begin
          if (scl_rise) begin
            shift_nxt   = {shift[6:0], sda};
            bit_cnt_nxt = bit_cnt_inc(bit_cnt);
          end else if (scl_fall && bit_cnt == BITS_PER_BYTE) begin
            state_nxt    = ST_WR_ACK;
            bit_cnt_nxt  = '0;
            rx_data_nxt  = shift;
            rx_valid_nxt = 1'b1;
            sda_oe_nxt   = drive_for_level(ACK_LEVEL);
          end
        end

        ST_WR_ACK: begin
          if (scl_rise) begin
            bit_cnt_nxt = bit_cnt_inc(bit_cnt);
          end else if (scl_fall && bit_cnt != 4'd0) begin
            state_nxt   = ST_WR_DATA;
            bit_cnt_nxt = '0;
            sda_oe_nxt  = 1'b0;
          end
        end

        ST_RD_DATA: begin
          if (scl_rise) begin
            bit_cnt_nxt = bit_cnt_inc(bit_cnt);
          end else if (scl_fall && bit_cnt == BITS_PER_BYTE) begin
            state_nxt   = ST_RD_ACK;
            bit_cnt_nxt = '0;
            sda_oe_nxt  = 1'b0;
          end else if (scl_fall && bit_cnt != 4'd0) begin
            shift_nxt  = {shift[6:0], 1'b0};
            sda_oe_nxt = drive_for_level(shift[6]);
          end
        end

        ST_RD_ACK: begin
          if (scl_rise) begin
            if (sda == NACK_LEVEL) begin
              state_nxt   = ST_IDLE;
              bit_cnt_nxt = '0;
              busy_nxt    = 1'b0;
            end else begin
              bit_cnt_nxt = bit_cnt_inc(bit_cnt);
            end
          end else if (scl_fall && bit_cnt != 4'd0) begin
            state_nxt   = ST_RD_DATA;
            bit_cnt_nxt = '0;
            shift_nxt   = tx_data;
            tx_load_nxt = 1'b1;
            sda_oe_nxt  = drive_for_level(tx_data[7]);
          end
        end

        default: begin
          state_nxt   = ST_IDLE;
          bit_cnt_nxt = '0;
          sda_oe_nxt  = 1'b0;
          busy_nxt    = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_target.sv
// tb_i2c_target
//   Drives an open-drain I2C bus shared by two targets (0x50 and 0x51) from
//   a bit-level master model and checks the 0x50 target against expected
//   transaction outcomes; the 0x51 target must stay silent throughout.
module tb_i2c_target;
  import i2c_pkg::*;

  localparam logic [6:0] TGT   = 7'h50;
  localparam logic [6:0] OTHER = 7'h51;
  localparam int         Q     = 4;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       scl_m = 1'b1;
  logic       sda_m = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic       sda_line;

  logic       sda_oe, rx_valid, tx_load, busy;
  logic [7:0] rx_data;
  logic       sda_oe51, rx_valid51, tx_load51, busy51;
  logic [7:0] rx_data51;

  int tests_run    = 0;
  int tests_failed = 0;
  int rx_pulses    = 0;
  int tx_pulses    = 0;
  logic [7:0] rx_log[$];
  bit oe51_seen    = 1'b0;
  bit rxv51_seen   = 1'b0;
  bit busy51_seen  = 1'b0;

  assign sda_line = sda_m & ~sda_oe & ~sda_oe51;

  always #5 clock = ~clock;

  i2c_target #(.ADDRESS(TGT), .SYNC_STAGES(2)) dut (
    .clock   (clock),
    .reset   (reset),
    .scl_in  (scl_m),
    .sda_in  (sda_line),
    .sda_oe  (sda_oe),
    .tx_data (tx_data),
    .rx_data (rx_data),
    .rx_valid(rx_valid),
    .tx_load (tx_load),
    .busy    (busy)
  );

  i2c_target #(.ADDRESS(OTHER), .SYNC_STAGES(3)) dut51 (
    .clock   (clock),
    .reset   (reset),
    .scl_in  (scl_m),
    .sda_in  (sda_line),
    .sda_oe  (sda_oe51),
    .tx_data (tx_data),
    .rx_data (rx_data51),
    .rx_valid(rx_valid51),
    .tx_load (tx_load51),
    .busy    (busy51)
  );

  // Pulse monitors, sampled on the falling clock edge.
  always @(negedge clock) begin
    if (rx_valid) begin
      rx_pulses = rx_pulses + 1;
      rx_log.push_back(rx_data);
    end
    if (tx_load)    tx_pulses = tx_pulses + 1;
    if (sda_oe51)   oe51_seen = 1'b1;
    if (rx_valid51) rxv51_seen = 1'b1;
    if (busy51)     busy51_seen = 1'b1;
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic i2c_start();
    sda_m = 1'b1; wait_clk(Q);
    scl_m = 1'b1; wait_clk(Q);
    sda_m = 1'b0; wait_clk(Q);
    scl_m = 1'b0; wait_clk(Q);
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; wait_clk(Q);
    scl_m = 1'b1; wait_clk(Q);
    sda_m = 1'b1; wait_clk(2*Q);
  endtask

  task automatic bit_out(input logic b);
    wait_clk(Q);
    sda_m = b;
    wait_clk(Q);
    scl_m = 1'b1;
    wait_clk(2*Q);
    scl_m = 1'b0;
  endtask

  task automatic bit_in(output logic b);
    sda_m = 1'b1;
    wait_clk(2*Q);
    scl_m = 1'b1;
    wait_clk(Q);
    b = sda_line;
    wait_clk(Q);
    scl_m = 1'b0;
  endtask

  task automatic write_byte(input logic [7:0] d, output logic acked);
    logic b;
    for (int i = 7; i >= 0; i--) bit_out(d[i]);
    bit_in(b);
    acked = ~b;
  endtask

  task automatic read_byte(input logic master_ack, input logic [7:0] next_tx,
                           output logic [7:0] d);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      bit_in(b);
      d[i] = b;
      if (i == 7) tx_data = next_tx;
    end
    bit_out(master_ack ? 1'b0 : 1'b1);
  endtask

  // One complete transaction: START, address, payload, STOP. The expected
  // outcome follows from the bus rules alone: only our address is ACKed,
  // written bytes come out of rx_data in order, read bytes are the tx_data
  // values presented before each byte, the master NACKs the final read.
  task automatic applyStimulus(input logic [6:0] addr, input logic rw,
                               input logic [7:0] vals[$]);
    logic       acked;
    logic [7:0] got;
    logic [7:0] nxt;
    bit         match;
    int         rx0, tx0, n;
    match = (addr == TGT);
    n     = vals.size();
    rx0   = rx_pulses;
    tx0   = tx_pulses;
    rx_log.delete();
    if (rw) tx_data = vals[0];
    i2c_start();
    write_byte({addr, rw}, acked);
    checkOutput("addr_ack", 32'(acked), 32'(match));
    checkOutput("busy_addr", 32'(busy), 32'(match));
    if (match) begin
      for (int k = 0; k < n; k++) begin
        if (!rw) begin
          write_byte(vals[k], acked);
          checkOutput("wr_ack", 32'(acked), 32'd1);
        end else begin
          nxt = (k < n-1) ? vals[k+1] : 8'($urandom_range(0, 255));
          read_byte(k < n-1, nxt, got);
          checkOutput("rd_byte", 32'(got), 32'(vals[k]));
        end
      end
      if (rw) checkOutput("busy_nack", 32'(busy), 32'd0);
    end
    i2c_stop();
    checkOutput("busy_stop", 32'(busy), 32'd0);
    checkOutput("oe_stop", 32'(sda_oe), 32'd0);
    checkOutput("rx_count", 32'(rx_pulses - rx0), (match && !rw) ? 32'(n) : 32'd0);
    checkOutput("tx_count", 32'(tx_pulses - tx0), (match && rw) ? 32'(n) : 32'd0);
    if (match && !rw) begin
      for (int k = 0; k < n && k < rx_log.size(); k++)
        checkOutput("rx_byte", 32'(rx_log[k]), 32'(vals[k]));
    end
  endtask

  initial begin
    logic [7:0] q[$];
    logic       acked;
    logic [7:0] got;
    logic [6:0] a;
    int         rx0, tx0;

    // Reset state
    wait_clk(3);
    checkOutput("rst_oe", 32'(sda_oe), 32'd0);
    checkOutput("rst_rx_data", 32'(rx_data), 32'd0);
    checkOutput("rst_rx_valid", 32'(rx_valid), 32'd0);
    checkOutput("rst_tx_load", 32'(tx_load), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    reset = 1'b1;
    wait_clk(4);

    // Single write of 0xFE
    q = '{8'hFE};
    applyStimulus(TGT, 1'b0, q);

    // Single read of 0xCC with NACK; target must be idle before STOP
    tx_data = 8'hCC;
    tx0 = tx_pulses;
    i2c_start();
    write_byte({TGT, 1'b1}, acked);
    checkOutput("r31_addr_ack", 32'(acked), 32'd1);
    read_byte(1'b0, 8'h00, got);
    checkOutput("r31_byte", 32'(got), 32'hCC);
    checkOutput("r31_tx_load", 32'(tx_pulses - tx0), 32'd1);
    checkOutput("r31_state", 32'(dut.state), 32'(ST_IDLE));
    checkOutput("r31_oe", 32'(sda_oe), 32'd0);
    checkOutput("r31_busy", 32'(busy), 32'd0);
    i2c_stop();

    // Two-byte read, ACK then NACK
    q = '{8'hCC, 8'hCD};
    applyStimulus(TGT, 1'b1, q);

    // Repeated START after 4 data bits, then read 0xBB
    rx0 = rx_pulses;
    tx0 = tx_pulses;
    i2c_start();
    write_byte({TGT, 1'b0}, acked);
    checkOutput("r33_addr_w", 32'(acked), 32'd1);
    bit_out(1'b1); bit_out(1'b0); bit_out(1'b1); bit_out(1'b1);
    i2c_start();
    tx_data = 8'hBB;
    write_byte({TGT, 1'b1}, acked);
    checkOutput("r33_addr_r", 32'(acked), 32'd1);
    read_byte(1'b0, 8'h00, got);
    checkOutput("r33_byte", 32'(got), 32'hBB);
    i2c_stop();
    checkOutput("r33_no_rx", 32'(rx_pulses - rx0), 32'd0);
    checkOutput("r33_tx_load", 32'(tx_pulses - tx0), 32'd1);

    // Reset during the data ACK bit, then a clean write of 0x01
    i2c_start();
    write_byte({TGT, 1'b0}, acked);
    checkOutput("r34_addr_ack", 32'(acked), 32'd1);
    for (int i = 7; i >= 0; i--) bit_out(((8'h5A >> i) & 8'h01) != 8'h00);
    wait_clk(Q + 2);
    checkOutput("r34_ack_drive", 32'(sda_oe), 32'd1);
    reset = 1'b0;
    #1;
    checkOutput("r34_async_release", 32'(sda_oe), 32'd0);
    checkOutput("r34_busy", 32'(busy), 32'd0);
    checkOutput("r34_rx_cleared", 32'(rx_data), 32'd0);
    wait_clk(2);
    sda_m = 1'b1;
    wait_clk(1);
    reset = 1'b1;
    wait_clk(Q);
    scl_m = 1'b1; wait_clk(2*Q);
    scl_m = 1'b0; wait_clk(Q);
    i2c_stop();
    q = '{8'h01};
    applyStimulus(TGT, 1'b0, q);

    // Randomized transactions: our address or a foreign one (never 0x51)
    for (int t = 0; t < 20; t++) begin
      if ($urandom_range(0, 3) != 0) a = TGT;
      else begin
        do a = 7'($urandom_range(0, 127)); while (a == TGT || a == OTHER);
      end
      q.delete();
      for (int k = 0; k < int'($urandom_range(1, 3)); k++)
        q.push_back(8'($urandom_range(0, 255)));
      applyStimulus(a, 1'($urandom_range(0, 1)), q);
    end

    // The 0x51 target saw all of this traffic and must never have reacted
    checkOutput("t51_oe", 32'(oe51_seen), 32'd0);
    checkOutput("t51_rx_valid", 32'(rxv51_seen), 32'd0);
    checkOutput("t51_busy", 32'(busy51_seen), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/i2c_target.md
I2C_TARGET -- requirements
Module: i2c_target

Interface
REQ-001 Parameter ADDRESS, default 7'h50, 7-bit target address this instance answers to.
REQ-002 Parameter SYNC_STAGES, default 2, synchronizer depth on scl_in/sda_in, legal values 2..3.
REQ-003 clock  input  1  system clock, all logic on rising edge; clock shall run at least 8x the SCL rate.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 scl_in  input  1  bus SCL level, asynchronous to clock.
REQ-006 sda_in  input  1  bus SDA level, asynchronous to clock.
REQ-007 sda_oe  output  1  1 = pull SDA low (open-drain); 0 = release.
REQ-008 tx_data  input  8  byte returned on a read; captured at the start of each read byte.
REQ-009 rx_data  output  8  last byte written by the master.
REQ-010 rx_valid  output  1  single-cycle pulse when rx_data is updated.
REQ-011 tx_load  output  1  single-cycle pulse when tx_data is captured.
REQ-012 busy  output  1  high from own-address match until STOP, repeated START or NACK release.

Function
REQ-013 scl_in/sda_in shall pass SYNC_STAGES flops; all decisions use synchronized levels and one-cycle-delayed copies for edge detection.
REQ-014 START = synced SDA falling while synced SCL high; STOP = synced SDA rising while synced SCL high; either shall be detected in any state.
REQ-015 States: IDLE, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK.
REQ-016 START from any state -> ADDR, bit counter cleared (repeated START supported); STOP from any state -> IDLE, sda_oe=0.
REQ-017 Bits shall be sampled on the synced SCL rising edge, MSB first; sda_oe changes only on the synced SCL falling edge.
REQ-018 ADDR: after 8 bits, if bits[7:1]==ADDRESS, ADDR_ACK with sda_oe=1 for the 9th SCL period; otherwise IDLE, sda_oe stays 0.
REQ-019 ADDR_ACK exit on the falling edge after the 9th clock: R/W=0 -> WR_DATA, R/W=1 -> RD_DATA.
REQ-020 WR_DATA: after 8 bits, rx_data updated and rx_valid pulses the same cycle; -> WR_ACK, sda_oe=1 for the 9th period, then WR_DATA.
REQ-021 RD_DATA: tx_data captured and tx_load pulses on entry; sda_oe = ~shift[7] per bit; after 8 bits release SDA -> RD_ACK.
REQ-022 RD_ACK: master SDA sampled on the 9th rising edge; 0 (ACK) -> RD_DATA with the next tx_data; 1 (NACK) -> IDLE, busy=0.
REQ-023 Bit counter is 4 bits, saturates at 8, never wraps; SCL edges in IDLE are ignored.
REQ-024 A START or STOP mid-byte shall discard the partial byte; rx_valid shall not pulse.
REQ-025 START and SCL edge in the same cycle: START wins.

Reset
REQ-026 On reset low: state=IDLE, sda_oe=0, rx_data=8'h00, rx_valid=0, tx_load=0, busy=0, counters and shift register cleared, synchronizers preset to 1 (idle bus).
REQ-027 Reset asserted mid-transfer shall release SDA asynchronously; after reset release, the block waits for a new START.

Structure
REQ-028 Package i2c_pkg shall hold the state enum, the ACK/NACK level constants and the bit-count constant 8; it is shared with the master.
REQ-029 Sub-module i2c_line_sync shall contain the synchronizers and the START/STOP/SCL-edge detectors; the FSM and shift register stay in i2c_target.

Verification
REQ-030 Write 0x50+W, data 8'hFE, STOP -> address ACK, data ACK, rx_data=8'hFE, one rx_valid pulse, busy low after STOP.
REQ-031 tx_data=8'hCC; read 0x50+R, master NACK -> SDA shows 11001100, one tx_load, state IDLE, sda_oe=0.
REQ-032 Instance ADDRESS=7'h51 receives 0x50+W -> sda_oe never asserted, no rx_valid, busy stays 0.
REQ-033 Repeated START after 4 data bits, then 0x50+R with tx_data=8'hBB -> partial byte dropped, BB returned.
REQ-034 Reset pulsed low during the data ACK bit -> sda_oe=0 within the same cycle; next write 8'h01 received correctly.
REQ-035 Two-byte read 8'hCC then 8'hCD, master ACK then NACK -> two tx_load pulses, bytes returned in order.
